// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - frame loader from sample stream into FFT cache write port
//
// Purpose:
//   Accepts 16-bit samples on a valid/ready handshake and writes one frame of
//   2^LOG2N samples into the sample cache. The frame is then held until the FFT
//   engine acknowledges it, after which the loader returns to IDLE.
//
// Configuration:
//   FFT_LOADER_BITREV_EN  defined: write address is the bit-reverse of the
//                         sample index over LOG2N bits.
//                         undefined: natural-order addresses.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                arm one frame load (sampled only in IDLE)
//   abort                synchronous cancel, returns to IDLE
//   s_data/s_valid/s_ready  sample stream handshake
//   mem_data/mem_adr/mem_write  cache write port (registered)
//   frame_done           one-cycle pulse alongside the final write
//   frame_ack            engine owns the held frame, release it
//   busy                 state is LOAD or HOLD
//   overrun              sticky: s_valid seen outside LOAD
module fft_input_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int LOG2N  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_write,
  output logic              frame_done,
  input  logic              frame_ack,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [LOG2N-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
  logic                mem_write_q, mem_write_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;

  logic                xfer;
  logic                last_sample;
  logic                start_accepted;
  logic [ADDR_W-1:0]   addr_of_cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks every other transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = LOAD;
        LOAD:    if (xfer && last_sample) state_d = HOLD;
        HOLD:    if (frame_ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State-decoded outputs; abort blocks the handshake in the same cycle.
  assign s_ready = (state_q == LOAD) && !abort;
  assign busy    = (state_q != IDLE);

  assign xfer           = s_valid && s_ready;
  assign last_sample    = (cnt_q == '1);
  assign start_accepted = (state_q == IDLE) && start && !abort;

  // Cache address for the current sample index; bits above LOG2N stay zero.
  always_comb begin
    addr_of_cnt = '0;
`ifdef FFT_LOADER_BITREV_EN
    for (int i = 0; i < LOG2N; i++) begin
      addr_of_cnt[i] = cnt_q[LOG2N-1-i];
    end
`else
    addr_of_cnt[LOG2N-1:0] = cnt_q;
`endif
  end

  // Datapath next values
  always_comb begin
    cnt_d        = cnt_q;
    mem_data_d   = mem_data_q;
    mem_adr_d    = mem_adr_q;
    mem_write_d  = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    if (abort || start_accepted) begin
      cnt_d = '0;
    end else if (xfer) begin
      mem_data_d   = s_data;
      mem_adr_d    = addr_of_cnt;
      mem_write_d  = 1'b1;
      // Counter wraps to zero naturally on the final sample.
      cnt_d        = cnt_q + LOG2N'(1);
      frame_done_d = last_sample;
    end

    // A fresh frame clears the flag even if stray s_valid arrives alongside start.
    if (start_accepted) begin
      overrun_d = 1'b0;
    end else if ((state_q != LOAD) && s_valid) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      mem_data_q   <= '0;
      mem_adr_q    <= '0;
      mem_write_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      mem_data_q   <= mem_data_d;
      mem_adr_q    <= mem_adr_d;
      mem_write_q  <= mem_write_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mem_data   = mem_data_q;
  assign mem_adr    = mem_adr_q;
  assign mem_write  = mem_write_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Upstream stage of the FFT sample cache: accepts a stream of 16-bit samples over a valid/ready handshake and writes one frame of 2^LOG2N samples into the 4096×16 cache through its write port (data, write address, write strobe). Addresses are bit-reversed so the in-place FFT engine downstream reads natural-order butterflies. The loader holds the frame until the engine acknowledges it, then re-arms.

## Interface
- ADDR_W, 12, cache address width.
- DATA_W, 16, sample and cache word width.
- LOG2N, 12, log2 of frame length; legal 1..ADDR_W.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  arm one frame load; sampled only in IDLE.
- abort  in  1  synchronous cancel of current frame.
- s_data  in  DATA_W  input sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a sample this cycle.
- mem_data  out  DATA_W  to cache data_in.
- mem_adr  out  ADDR_W  to cache write_adr.
- mem_write  out  1  to cache write strobe.
- frame_done  out  1  one-cycle pulse, frame fully written.
- frame_ack  in  1  FFT engine has consumed/owns the frame; release.
- busy  out  1  state is LOAD or HOLD.
- overrun  out  1  sticky: s_valid seen while not in LOAD.

## Operation
- States: IDLE, LOAD, HOLD. Reset -> IDLE.
- IDLE: s_ready=0. start=1 -> LOAD; sample counter cnt (LOG2N bits) cleared, overrun cleared.
- LOAD: s_ready=1. Transfer = s_valid & s_ready. Per transfer: mem_data<=s_data, mem_adr<=addr(cnt), mem_write<=1 next cycle, cnt<=cnt+1. Without transfer mem_write<=0, mem_data/mem_adr hold.
- Transfer with cnt = 2^LOG2N−1 -> HOLD; cnt wraps to 0; frame_done<=1 (coincides with final mem_write).
- HOLD: s_ready=0, no writes. frame_ack=1 -> IDLE. frame_ack in IDLE/LOAD ignored.
- addr(cnt): LOG2N-bit value zero-extended to ADDR_W; bits above LOG2N always 0.
- abort=1 in any state -> IDLE next cycle, cnt=0, no transfer accepted that cycle (s_ready forced 0 combinationally), frame_done not pulsed; a mem_write already registered from the previous cycle still completes.
- Priority: rst_n > abort > frame_ack/start > transfer.
- overrun: set when s_valid=1 in IDLE or HOLD; cleared only by accepted start or reset.
- busy = (state != IDLE), registered-state derived.

## Timing
- All outputs registered except s_ready and busy (decoded from state register; s_ready also gated by abort).
- Reset values: s_ready 0, mem_data 0, mem_adr 0, mem_write 0, frame_done 0, busy 0, overrun 0, cnt 0.
- start at edge T -> s_ready=1 in cycle T+1.
- Transfer at edge T -> mem_write/mem_adr/mem_data valid in cycle T+1; cache stores at edge T+1. Latency 1.
- Full-rate: back-to-back transfers give one write per cycle, no bubbles.
- Final transfer at T -> s_ready=0 and frame_done=1 in T+1; frame_done=0 in T+2.
- frame_ack at T -> IDLE at T+1; earliest new start sampled at T+1, s_ready at T+2.

## Configuration
- FFT_LOADER_BITREV_EN defined: addr(cnt) = bit-reverse of cnt over LOG2N bits.
- Undefined: addr(cnt) = cnt (natural order); all other behaviour identical.

## Test plan
- LOG2N=3, BITREV on, start then samples 0x0010..0x0017 back-to-back -> writes at addresses 0,4,2,6,1,5,3,7 with data 0x0010..0x0017, one per cycle, frame_done one pulse with last write.
- Same with macro undefined -> addresses 0..7 in order.
- LOG2N=3, s_valid toggled 1/0 each cycle -> exactly 8 writes, mem_write low on idle cycles, frame_done after 8th; s_ready drops following cycle.
- s_valid=1 in HOLD with 0xBEEF -> no mem_write, overrun=1; frame_ack then start -> overrun=0, busy=1.
- abort after 3 transfers -> IDLE next cycle, 3 writes only, no frame_done; next frame starts at address 0.
- rst_n low mid-LOAD (async, between edges) -> all outputs reset immediately; after release, start yields write to address 0.
